// File: rtl/resp_misr_compactor.sv
// resp_misr_compactor: folds each accepted response vector into a Galois MISR
// over a fixed-length run, then holds the final signature and a golden compare.
//
// Ports:
//   CK            clock, all state updates on posedge
//   RST           synchronous active-high reset
//   start         begin (or re-arm) a run; honoured in IDLE and DONE only
//   resp_in       response vector from the circuit under test
//   resp_mask     (RESP_XMASK_EN only) bits set here are folded in as 0
//   resp_valid    resp_in is valid this cycle
//   busy          high while a run is in progress
//   done          high once CYCLES samples have been absorbed
//   signature     current MISR contents
//   sample_count  samples accepted in the current run
//   pass          done && signature == GOLDEN
//
// Optional feature macro: RESP_XMASK_EN (adds resp_mask, masks X bits).
module resp_misr_compactor #(
    parameter int unsigned      WIDTH  = 39,
    parameter int unsigned      CYCLES = 100,
    parameter logic [WIDTH-1:0] POLY   = WIDTH'(64'h63),
    parameter logic [WIDTH-1:0] SEED   = '0,
    parameter logic [WIDTH-1:0] GOLDEN = '0
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] resp_in,
`ifdef RESP_XMASK_EN
    input  logic [WIDTH-1:0] resp_mask,
`endif
    input  logic             resp_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] signature,
    output logic [15:0]      sample_count,
    output logic             pass
);

    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] sig_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] fold_term;

    // Term folded into the MISR; masked bits are forced to 0 even when X/Z.
    always_comb begin
`ifdef RESP_XMASK_EN
        fold_term = resp_in & ~resp_mask;
`else
        fold_term = resp_in;
`endif
    end

    // Next-state, next-signature and next-count.
    always_comb begin
        state_nxt = state;
        sig_nxt   = signature;
        cnt_nxt   = sample_count;
        case (state)
            ST_IDLE, ST_DONE: begin
                // A sample arriving with start is not absorbed.
                if (start) begin
                    state_nxt = ST_RUN;
                    sig_nxt   = SEED;
                    cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                if (resp_valid) begin
                    sig_nxt = {signature[WIDTH-2:0], 1'b0}
                            ^ (signature[WIDTH-1] ? POLY : '0)
                            ^ fold_term;
                    cnt_nxt = sample_count + CNT_W'(1);
                    if (cnt_nxt == CNT_W'(CYCLES)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, signature and count registers; reset has priority over start.
    always_ff @(posedge CK) begin
        if (RST) begin
            state        <= ST_IDLE;
            signature    <= SEED;
            sample_count <= '0;
        end else begin
            state        <= state_nxt;
            signature    <= sig_nxt;
            sample_count <= cnt_nxt;
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign pass = (state == ST_DONE) && (signature == GOLDEN);

endmodule
